prga_decrypt: RTL and testbench



---
 rtl/prga_pkg.sv | 23 ++
 rtl/prga_if.sv | 46 ++++
 rtl/prga_decrypt.sv | 151 +++++++++++++++
 tb/tb_prga_decrypt.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prga_pkg.sv
// prga_pkg: shared types and defaults for the RC4 PRGA / decrypt stage.
package prga_pkg;

  localparam int MSG_LEN_DEFAULT = 32;
  localparam int KW_DEFAULT      = 6;
  localparam int S_AW            = 8;

  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    LAT_I,
    RD_J,
    LAT_J,
    WR_I,
    WR_J,
    RD_F,
    LAT_F,
    EMIT,
    WAIT_ACK,
    DONE
  } state_t;

endpackage

// File: rtl/prga_if.sv
// prga_if: S RAM, encrypted ROM, decrypted RAM and checker handshake of the
// PRGA / decrypt stage. The master modport is the PRGA side.
// Optional: PRGA_CYCLE_CNT_EN adds cycle_cnt.
interface prga_if import prga_pkg::*; #(
  parameter int KW = KW_DEFAULT
);

  logic            start;
  logic [S_AW-1:0] s_addr;
  logic [7:0]      s_wrdata;
  logic            s_wren;
  logic [7:0]      s_rddata;
  logic [KW-1:0]   rom_addr;
  logic [7:0]      rom_rddata;
  logic [KW-1:0]   dec_addr;
  logic [7:0]      dec_wrdata;
  logic            dec_wren;
  logic            new_char;
  logic [7:0]      char_out;
  logic [KW-1:0]   k_out;
  logic            compared_char;
  logic            start_over;
  logic            done;
`ifdef PRGA_CYCLE_CNT_EN
  logic [31:0]     cycle_cnt;
`endif

  modport master (
    input  start, s_rddata, rom_rddata, compared_char, start_over,
    output s_addr, s_wrdata, s_wren, rom_addr, dec_addr, dec_wrdata,
           dec_wren, new_char, char_out, k_out, done
`ifdef PRGA_CYCLE_CNT_EN
    , output cycle_cnt
`endif
  );

  modport slave (
    output start, s_rddata, rom_rddata, compared_char, start_over,
    input  s_addr, s_wrdata, s_wren, rom_addr, dec_addr, dec_wrdata,
           dec_wren, new_char, char_out, k_out, done
`ifdef PRGA_CYCLE_CNT_EN
    , input cycle_cnt
`endif
  );

endinterface

// File: rtl/prga_decrypt.sv
// prga_decrypt: RC4 keystream generation and decryption ("loop 3").
// Swaps S[i]/S[j] per byte, XORs S[S[i]+S[j]] with the encrypted ROM byte,
// writes the plaintext to decrypted RAM and hands it to the checker.
// Optional: PRGA_CYCLE_CNT_EN adds a busy-cycle counter (cycle_cnt).
module prga_decrypt import prga_pkg::*; #(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int KW      = KW_DEFAULT
) (
  input  logic    clk,
  input  logic    resetm,
  prga_if.master  bus
);

  state_t          r_state;
  state_t          w_next;
  logic [S_AW-1:0] r_i;
  logic [S_AW-1:0] r_j;
  logic [7:0]      r_si;
  logic [7:0]      r_sj;
  logic [KW-1:0]   r_k;
  logic [7:0]      r_char;
  logic [KW-1:0]   w_k_inc;
  logic            w_abort;

  assign w_k_inc = r_k + KW'(1);
  assign w_abort = bus.start_over && (r_state != IDLE);

  // State register
  always_ff @(posedge clk or negedge resetm) begin
    if (!resetm) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; start_over outranks a simultaneous ack
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:     if (bus.start) w_next = RD_I;
        RD_I:     w_next = LAT_I;
        LAT_I:    w_next = RD_J;
        RD_J:     w_next = LAT_J;
        LAT_J:    w_next = WR_I;
        WR_I:     w_next = WR_J;
        WR_J:     w_next = RD_F;
        RD_F:     w_next = LAT_F;
        LAT_F:    w_next = EMIT;
        EMIT:     w_next = WAIT_ACK;
        WAIT_ACK: if (bus.compared_char)
                    w_next = (w_k_inc == KW'(MSG_LEN)) ? DONE : RD_I;
        DONE:     w_next = DONE;
        default:  w_next = IDLE;
      endcase
    end
  end

  // Index and byte registers: i, j, k, S[i], S[j] and the plaintext byte
  always_ff @(posedge clk or negedge resetm) begin
    if (!resetm) begin
      r_i    <= '0;
      r_j    <= '0;
      r_k    <= '0;
      r_si   <= '0;
      r_sj   <= '0;
      r_char <= '0;
    end else if (w_abort) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_i <= bus.start ? S_AW'(1) : '0;
          r_j <= '0;
          r_k <= '0;
        end
        LAT_I: begin
          r_si <= bus.s_rddata;
          r_j  <= r_j + bus.s_rddata;
        end
        LAT_J:    r_sj   <= bus.s_rddata;
        LAT_F:    r_char <= bus.s_rddata ^ bus.rom_rddata;
        WAIT_ACK: if (bus.compared_char) begin
                    r_k <= w_k_inc;
                    r_i <= r_i + S_AW'(1);
                  end
        default: ;
      endcase
    end
  end

  // Memory strobes and handshake outputs decoded from the current state
  always_comb begin
    bus.s_addr     = '0;
    bus.s_wrdata   = '0;
    bus.s_wren     = 1'b0;
    bus.rom_addr   = '0;
    bus.dec_addr   = '0;
    bus.dec_wrdata = '0;
    bus.dec_wren   = 1'b0;
    bus.new_char   = 1'b0;
    bus.char_out   = r_char;
    bus.k_out      = r_k;
    bus.done       = (r_state == DONE);
    case (r_state)
      RD_I: bus.s_addr = r_i;
      RD_J: bus.s_addr = r_j;
      WR_I: begin
        bus.s_addr   = r_i;
        bus.s_wrdata = r_sj;
        bus.s_wren   = 1'b1;
      end
      WR_J: begin
        bus.s_addr   = r_j;
        bus.s_wrdata = r_si;
        bus.s_wren   = 1'b1;
        bus.rom_addr = r_k;
      end
      RD_F: begin
        bus.s_addr   = r_si + r_sj;
        bus.rom_addr = r_k;
      end
      EMIT: begin
        bus.dec_addr   = r_k;
        bus.dec_wrdata = r_char;
        bus.dec_wren   = 1'b1;
        bus.new_char   = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PRGA_CYCLE_CNT_EN
  logic [31:0] r_cycle_cnt;

  // Busy-cycle counter: restarts with each pass, frozen in IDLE and DONE
  always_ff @(posedge clk or negedge resetm) begin
    if (!resetm)
      r_cycle_cnt <= '0;
    else if (r_state == IDLE && bus.start)
      r_cycle_cnt <= '0;
    else if (r_state != IDLE && r_state != DONE)
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
  end

  assign bus.cycle_cnt = r_cycle_cnt;
`endif

endmodule

// File: tb/tb_prga_decrypt.sv
// tb_prga_decrypt: bench for prga_decrypt with S RAM / ROM / decrypted RAM
// models and an RC4 reference computed directly on an array copy of S.
module tb_prga_decrypt;
  import prga_pkg::*;

  localparam int MSG = 32;
  localparam int KW  = 6;

  logic clk = 1'b0;
  logic resetm = 1'b0;

  prga_if #(.KW(KW)) bus();

  prga_decrypt #(.MSG_LEN(MSG), .KW(KW)) dut (
    .clk    (clk),
    .resetm (resetm),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] s_init   [256];
  logic [7:0] s_mem    [256];
  logic [7:0] rom      [64];
  logic [7:0] dec_mem  [64];
  logic [7:0] exp_char [MSG];
  logic [7:0] exp_s    [256];
  logic       s_load  = 1'b0;
  logic       dec_clr = 1'b0;
  int         dec_cnt = 0;
  int         nc_cnt  = 0;

  // Memory models: registered reads, one-cycle latency
  always @(posedge clk) begin
    if (s_load) for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
    else if (bus.s_wren) s_mem[bus.s_addr] <= bus.s_wrdata;
    bus.s_rddata   <= s_mem[bus.s_addr];
    bus.rom_rddata <= rom[bus.rom_addr];
    if (dec_clr) begin
      dec_cnt <= 0;
      nc_cnt  <= 0;
    end else begin
      if (bus.dec_wren) begin
        dec_mem[bus.dec_addr] <= bus.dec_wrdata;
        dec_cnt <= dec_cnt + 1;
      end
      if (bus.new_char) nc_cnt <= nc_cnt + 1;
    end
  end

  // RC4 PRGA reference over the whole message
  task automatic compute_expected();
    int i = 0, j = 0;
    logic [7:0] t;
    for (int n = 0; n < 256; n++) exp_s[n] = s_init[n];
    for (int k = 0; k < MSG; k++) begin
      i = (i + 1) % 256;
      j = (j + exp_s[i]) % 256;
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
      exp_char[k] = exp_s[(exp_s[i] + exp_s[j]) % 256] ^ rom[k];
    end
  endtask

  task automatic init_identity();
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 0; n < 64; n++) rom[n] = 8'h00;
  endtask

  task automatic init_random();
    int r;
    logic [7:0] t;
    for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
    for (int n = 255; n > 0; n--) begin
      r = int'($urandom_range(n, 0));
      t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
    end
    for (int n = 0; n < 64; n++) rom[n] = 8'($urandom);
  endtask

  task automatic load_s();
    @(negedge clk); s_load = 1'b1; dec_clr = 1'b1;
    @(negedge clk); s_load = 1'b0; dec_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
  endtask

  task automatic pulse_start_over();
    @(negedge clk); bus.start_over = 1'b1;
    @(negedge clk); bus.start_over = 1'b0;
  endtask

  task automatic wait_nc(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.new_char) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ack_after(input int d);
    repeat (d) @(posedge clk);
    @(negedge clk); bus.compared_char = 1'b1;
    @(negedge clk); bus.compared_char = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.s_wren !== 1'b0 || bus.dec_wren !== 1'b0 || bus.new_char !== 1'b0 || bus.done !== 1'b0)
      begin errors++; $display("FAIL reset_strobes wren=%b dwren=%b nc=%b done=%b", bus.s_wren, bus.dec_wren, bus.new_char, bus.done); end
    checks++; if (bus.s_addr !== 8'h00 || bus.rom_addr !== 6'd0 || bus.dec_addr !== 6'd0)
      begin errors++; $display("FAIL reset_addr s=%0h rom=%0h dec=%0h expected 0", bus.s_addr, bus.rom_addr, bus.dec_addr); end
    checks++; if (bus.char_out !== 8'h00 || bus.k_out !== 6'd0)
      begin errors++; $display("FAIL reset_regs char=%0h k=%0d expected 0", bus.char_out, bus.k_out); end
    @(negedge clk); resetm = 1'b1;
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.s_addr !== 8'h00 || bus.s_wren !== 1'b0)
      begin errors++; $display("FAIL idle_after_reset s_addr=%0h wren=%b expected 0", bus.s_addr, bus.s_wren); end
  endtask

  task automatic test_first_byte_no_ack();
    logic [7:0] wa [4];
    logic [7:0] wd [4];
    int wr_cnt = 0, n_nc = 0, first_nc = 0;
    init_identity(); compute_expected(); load_s();
    @(negedge clk); bus.start = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) bus.start = 1'b0;
      if (bus.s_wren) begin
        if (wr_cnt < 4) begin wa[wr_cnt] = bus.s_addr; wd[wr_cnt] = bus.s_wrdata; end
        wr_cnt++;
      end
      if (bus.new_char) begin n_nc++; if (first_nc == 0) first_nc = cyc; end
    end
    checks++; if (wr_cnt !== 2) begin errors++; $display("FAIL first_wr_count got=%0d expected 2", wr_cnt); end
    checks++; if (wr_cnt >= 2 && (wa[0] !== 8'd1 || wa[1] !== 8'd1 || wd[0] !== 8'd1 || wd[1] !== 8'd1))
      begin errors++; $display("FAIL first_wr_pair addr=%0h,%0h data=%0h,%0h expected 1,1 1,1", wa[0], wa[1], wd[0], wd[1]); end
    checks++; if (first_nc !== 9) begin errors++; $display("FAIL first_latency got=%0d expected 9", first_nc); end
    checks++; if (n_nc !== 1) begin errors++; $display("FAIL no_ack_pulses got=%0d expected 1", n_nc); end
    checks++; if (bus.char_out !== exp_char[0] || exp_char[0] !== 8'h02)
      begin errors++; $display("FAIL first_char got=%0h expected %0h", bus.char_out, exp_char[0]); end
    checks++; if (bus.k_out !== 6'd0 || bus.new_char !== 1'b0 || bus.s_addr !== 8'h00)
      begin errors++; $display("FAIL no_ack_hold k=%0d nc=%b s_addr=%0h expected 0", bus.k_out, bus.new_char, bus.s_addr); end
    checks++; if (s_mem[1] !== 8'd1 || s_mem[2] !== 8'd2)
      begin errors++; $display("FAIL i_eq_j_swap S1=%0h S2=%0h expected 1 2", s_mem[1], s_mem[2]); end
    pulse_start_over();
  endtask

  task automatic test_full_pass(input bit rnd);
    bit ok;
    int bad;
    if (rnd) init_random(); else init_identity();
    compute_expected(); load_s(); pulse_start();
    for (int k = 0; k < MSG; k++) begin
      wait_nc(ok);
      checks++; if (!ok) begin errors++; $display("FAIL pass_timeout byte=%0d new_char got=0 expected 1", k); break; end
      checks++; if (bus.char_out !== exp_char[k] || bus.k_out !== KW'(k))
        begin errors++; $display("FAIL pass_char byte=%0d got=%0h k=%0d expected %0h k=%0d", k, bus.char_out, bus.k_out, exp_char[k], k); end
      ack_after(rnd ? int'($urandom_range(4, 1)) : 3);
    end
    for (int c = 0; c < 20 && bus.done !== 1'b1; c++) begin @(posedge clk); #1; end
    checks++; if (bus.done !== 1'b1 || bus.k_out !== KW'(MSG))
      begin errors++; $display("FAIL pass_done done=%b k=%0d expected 1 %0d", bus.done, bus.k_out, MSG); end
    checks++; if (dec_cnt !== MSG || nc_cnt !== MSG)
      begin errors++; $display("FAIL pass_counts writes=%0d pulses=%0d expected %0d", dec_cnt, nc_cnt, MSG); end
    bad = 0;
    for (int k = 0; k < MSG; k++) if (dec_mem[k] !== exp_char[k]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL pass_dec_ram bad_bytes=%0d expected 0", bad); end
    bad = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL pass_s_ram bad_entries=%0d expected 0", bad); end
`ifdef PRGA_CYCLE_CNT_EN
    begin
      logic [31:0] cc;
      cc = bus.cycle_cnt;
      repeat (3) @(posedge clk); #1;
      checks++; if (bus.cycle_cnt !== cc || cc < 32'(10 * MSG))
        begin errors++; $display("FAIL cycle_cnt_hold got=%0d was=%0d min=%0d", bus.cycle_cnt, cc, 10 * MSG); end
    end
`endif
    repeat (3) @(posedge clk); #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL done_hold got=%b expected 1", bus.done); end
    pulse_start_over(); #1;
    checks++; if (bus.done !== 1'b0 || bus.k_out !== 6'd0)
      begin errors++; $display("FAIL done_clear done=%b k=%0d expected 0 0", bus.done, bus.k_out); end
  endtask

  task automatic test_start_over_wrj();
    bit ok, found;
    init_identity(); compute_expected(); load_s(); pulse_start();
    for (int k = 0; k < 5; k++) begin wait_nc(ok); ack_after(1); end
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.s_wren && bus.rom_addr == 6'd5) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL wrj_byte5 found=0 expected 1"); end
    bus.start_over = 1'b1;
    @(posedge clk); #1;
    bus.start_over = 1'b0;
    checks++; if (bus.s_wren !== 1'b0 || bus.k_out !== 6'd0 || bus.s_addr !== 8'h00 || bus.rom_addr !== 6'd0)
      begin errors++; $display("FAIL abort_idle wren=%b k=%0d s_addr=%0h rom=%0h expected 0", bus.s_wren, bus.k_out, bus.s_addr, bus.rom_addr); end
    load_s(); pulse_start();
    wait_nc(ok);
    checks++; if (!ok || bus.char_out !== exp_char[0] || bus.k_out !== 6'd0)
      begin errors++; $display("FAIL restart ok=%b char=%0h k=%0d expected %0h 0", ok, bus.char_out, bus.k_out, exp_char[0]); end
    pulse_start_over();
  endtask

  task automatic test_ack_abort();
    bit ok;
    init_identity(); compute_expected(); load_s(); pulse_start();
    wait_nc(ok);
    @(posedge clk);
    @(negedge clk); bus.compared_char = 1'b1; bus.start_over = 1'b1;
    @(posedge clk); #1;
    bus.compared_char = 1'b0; bus.start_over = 1'b0;
    checks++; if (bus.k_out !== 6'd0 || bus.s_addr !== 8'h00 || bus.done !== 1'b0)
      begin errors++; $display("FAIL ack_abort k=%0d s_addr=%0h done=%b expected 0", bus.k_out, bus.s_addr, bus.done); end
    repeat (12) @(posedge clk); #1;
    checks++; if (nc_cnt !== 1 || bus.s_addr !== 8'h00)
      begin errors++; $display("FAIL ack_abort_idle pulses=%0d s_addr=%0h expected 1 0", nc_cnt, bus.s_addr); end
  endtask

  task automatic test_async_reset();
    bit ok;
    init_identity(); compute_expected(); load_s(); pulse_start();
    wait_nc(ok); ack_after(1);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 resetm = 1'b0; #1;
    checks++; if (bus.char_out !== 8'h00 || bus.k_out !== 6'd0)
      begin errors++; $display("FAIL async_reset_regs char=%0h k=%0d expected 0", bus.char_out, bus.k_out); end
    checks++; if (bus.s_addr !== 8'h00 || bus.s_wren !== 1'b0 || bus.new_char !== 1'b0 || bus.dec_wren !== 1'b0)
      begin errors++; $display("FAIL async_reset_outs s_addr=%0h wren=%b nc=%b dwren=%b expected 0", bus.s_addr, bus.s_wren, bus.new_char, bus.dec_wren); end
    @(negedge clk); resetm = 1'b1;
    repeat (12) @(posedge clk); #1;
    checks++; if (bus.s_addr !== 8'h00 || bus.k_out !== 6'd0 || nc_cnt !== 1)
      begin errors++; $display("FAIL post_reset_idle s_addr=%0h k=%0d pulses=%0d expected 0 0 1", bus.s_addr, bus.k_out, nc_cnt); end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.compared_char = 1'b0;
    bus.start_over = 1'b0;
    test_reset();
    test_first_byte_no_ack();
    test_full_pass(1'b0);
    test_full_pass(1'b1);
    test_start_over_wrj();
    test_ack_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog time_limit reached expected completion");
    $fatal(1, "timeout");
  end

endmodule
